uart_transmitter: RTL

UART transmit stage that consumes the 16x oversampling tick (sample_ENABLE) from baud_controller and serialises one byte per frame onto Tx_D.
- Frame format: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- A single-entry holding register lets the host queue one byte while the current frame is on the line.
- Sits between the host write interface and the serial pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_transmitter_if.sv | 29 ++
 rtl/uart_tx_bit_timer.sv | 44 ++++
 rtl/uart_transmitter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the UART transmitter
//
// Purpose : default frame geometry, tick-counter width and transmit FSM states.
// Macro   : UART_TX_PARITY_EN adds the PARITY state encoding.
package uart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int CNT_W          = $clog2(DEF_OVERSAMPLE);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - host write / serial status bundle of the UART transmitter
//
// Purpose : groups the host handshake (Tx_EN, Tx_WR, Tx_DATA) with the
//           transmitter outputs (Tx_D, Tx_READY, Tx_BUSY, Tx_DONE, Tx_OVF).
// Modports: master = host side, slave = transmitter side.
interface uart_transmitter_if #(
  parameter int DATA_BITS = uart_pkg::DEF_DATA_BITS
);

  logic                 Tx_EN;
  logic                 Tx_WR;
  logic [DATA_BITS-1:0] Tx_DATA;
  logic                 Tx_D;
  logic                 Tx_READY;
  logic                 Tx_BUSY;
  logic                 Tx_DONE;
  logic                 Tx_OVF;

  modport master (
    output Tx_EN, Tx_WR, Tx_DATA,
    input  Tx_D, Tx_READY, Tx_BUSY, Tx_DONE, Tx_OVF
  );

  modport slave (
    input  Tx_EN, Tx_WR, Tx_DATA,
    output Tx_D, Tx_READY, Tx_BUSY, Tx_DONE, Tx_OVF
  );

endinterface

// File: rtl/uart_tx_bit_timer.sv
// rtl/uart_tx_bit_timer.sv - oversampling tick counter marking the end of each bit period
//
// Purpose : counts sample_ENABLE ticks; bit_end is high in the cycle whose
//           clock edge closes the current bit (count at OVERSAMPLE-1 and a tick).
// Ports   : clk, reset (async active-low), sample_ENABLE (tick), clear (hold at 0),
//           bit_end (one-cycle pulse).
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_ENABLE,
  input  logic clear,
  output logic bit_end
);

  localparam int            CW   = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    bit_end = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (sample_ENABLE) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        bit_end = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmit FSM with a single-entry holding register
//
// Purpose : serialises one byte per frame (start, DATA_BITS LSB first,
//           [even parity], stop) onto Tx_D, one bit per OVERSAMPLE ticks.
// Ports   : clk, reset (async active-low), sample_ENABLE (16x tick),
//           tx (uart_transmitter_if.slave: Tx_EN/Tx_WR/Tx_DATA in,
//           Tx_D/Tx_READY/Tx_BUSY/Tx_DONE/Tx_OVF out, all registered).
// Macro   : UART_TX_PARITY_EN inserts the even-parity bit after the data bits.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_ENABLE,
  uart_transmitter_if.slave    tx
);

  localparam int               IW       = $clog2(DATA_BITS);
  localparam logic [IW-1:0]    IDX_LAST = IW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_full_q, hold_full_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 tx_d_q, tx_d_d;
  logic                 done_q, done_d;
  logic                 ovf_q;
  logic                 busy_q;
  logic                 bit_end;
  logic                 start_frame;
  logic                 load;
  logic                 wr_ok;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  uart_tx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk           (clk),
    .reset         (reset),
    .sample_ENABLE (sample_ENABLE),
    .clear         (state_q == ST_IDLE),
    .bit_end       (bit_end)
  );

  // A write while the holding register is full is dropped; this includes the
  // edge that moves the held byte into the shifter, since Tx_READY is still low.
  assign wr_ok       = tx.Tx_WR && !hold_full_q;
  assign start_frame = hold_full_q && tx.Tx_EN;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d_d  = tx_d_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d_d = 1'b1;
        if (start_frame) begin
          state_d = ST_START;
          load    = 1'b1;
          tx_d_d  = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d_d  = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d_d  = parity_q;
`else
            state_d = ST_STOP;
            tx_d_d  = 1'b1;
`endif
          end else begin
            idx_d  = idx_q + 1'b1;
            tx_d_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d_d  = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          // Chain straight into the next start bit when a byte is waiting.
          if (start_frame) begin
            state_d = ST_START;
            load    = 1'b1;
            tx_d_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d_d  = 1'b1;
      end
    endcase
    if (load) shift_d = hold_q;
  end

  always_comb begin
    hold_full_d = hold_full_q;
    if (load)       hold_full_d = 1'b0;
    else if (wr_ok) hold_full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      idx_q       <= '0;
      tx_d_q      <= 1'b1;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      idx_q       <= idx_d;
      tx_d_q      <= tx_d_d;
      done_q      <= done_d;
      ovf_q       <= tx.Tx_WR && hold_full_q;
      busy_q      <= (state_d != ST_IDLE);
      if (wr_ok) hold_q <= tx.Tx_DATA;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is captured from the held byte as it is loaded, so the shifter
  // can be consumed freely during the data bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    parity_q <= 1'b0;
    else if (load) parity_q <= ^hold_q;
  end
`endif

  assign tx.Tx_D     = tx_d_q;
  assign tx.Tx_READY = !hold_full_q;
  assign tx.Tx_BUSY  = busy_q;
  assign tx.Tx_DONE  = done_q;
  assign tx.Tx_OVF   = ovf_q;

endmodule
